rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter.sv | 116 +++++++++++
 tb/tb_rf_write_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write port arbiter: pipeline writeback always wins, the multi-cycle unit and
// debug port share the remaining slots round-robin, and starving requesters stall the pipeline.
module rf_write_arbiter #(
   parameter int STARVE_LIMIT = 7
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        md_req,
   input  logic [4:0]  md_addr,
   input  logic [31:0] md_data,
   output logic        md_ack,
   input  logic        dbg_req,
   input  logic [4:0]  dbg_addr,
   input  logic [31:0] dbg_data,
   output logic        dbg_ack,
   output logic        rf_we,
   output logic [4:0]  rf_addr,
   output logic [31:0] rf_data,
   output logic        stall
);

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   typedef enum logic [1:0] {G_NONE, G_WB, G_MD, G_DBG} grant_t;
   typedef enum logic {RUN, STALL} state_t;

   state_t      state, state_nxt;
   grant_t      grant;
   logic        ptr_dbg;
   logic [2:0]  md_wait, dbg_wait, md_wait_nxt, dbg_wait_nxt;
   logic        md_elig, dbg_elig;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        wr_en;

   // A held request is not eligible in the cycle its ack is visible, so it is never granted twice.
   assign md_elig  = md_req  & ~md_ack;
   assign dbg_elig = dbg_req & ~dbg_ack;

   always_comb begin
      grant = G_NONE;
      if (wb_we)                  grant = G_WB;
      else if (md_elig && dbg_elig) grant = ptr_dbg ? G_DBG : G_MD;
      else if (md_elig)           grant = G_MD;
      else if (dbg_elig)          grant = G_DBG;
   end

   always_comb begin
      wr_addr = '0;
      wr_data = '0;
      case (grant)
         G_WB:  begin wr_addr = wb_addr;  wr_data = wb_data;  end
         G_MD:  begin wr_addr = md_addr;  wr_data = md_data;  end
         G_DBG: begin wr_addr = dbg_addr; wr_data = dbg_data; end
         default: ;
      endcase
   end

   // Register 0 is hardwired: the grant still completes, but nothing is written.
   assign wr_en = (grant != G_NONE) && (wr_addr != 5'd0);

   always_comb begin
      md_wait_nxt = '0;
      if (md_req && grant != G_MD)
         md_wait_nxt = (md_wait == LIMIT) ? LIMIT : md_wait + 3'd1;
      dbg_wait_nxt = '0;
      if (dbg_req && grant != G_DBG)
         dbg_wait_nxt = (dbg_wait == LIMIT) ? LIMIT : dbg_wait + 3'd1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:
            if ((md_wait == LIMIT && grant != G_MD) || (dbg_wait == LIMIT && grant != G_DBG))
               state_nxt = STALL;
         STALL:
            if (md_wait_nxt != LIMIT && dbg_wait_nxt != LIMIT)
               state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= RUN;
         ptr_dbg  <= 1'b0;
         md_wait  <= '0;
         dbg_wait <= '0;
         md_ack   <= 1'b0;
         dbg_ack  <= 1'b0;
         rf_we    <= 1'b0;
         rf_addr  <= '0;
         rf_data  <= '0;
      end else begin
         state    <= state_nxt;
         md_wait  <= md_wait_nxt;
         dbg_wait <= dbg_wait_nxt;
         md_ack   <= (grant == G_MD);
         dbg_ack  <= (grant == G_DBG);
         rf_we    <= wr_en;
         if (grant == G_MD)       ptr_dbg <= 1'b1;
         else if (grant == G_DBG) ptr_dbg <= 1'b0;
         if (wr_en) begin
            rf_addr <= wr_addr;
            rf_data <= wr_data;
         end
      end
   end

   assign stall = (state == STALL);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed and random stimulus for rf_write_arbiter, checked cycle by cycle against a
// requester-level behavioural model of the arbitration rules.
module tb_rf_write_arbiter;

   localparam int LIMIT = 7;

   logic        clock = 1'b0;
   logic        reset;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        md_req;
   logic [4:0]  md_addr;
   logic [31:0] md_data;
   logic        md_ack;
   logic        dbg_req;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic        dbg_ack;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic        stall;

   rf_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clock(clock), .reset(reset),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .md_req(md_req), .md_addr(md_addr), .md_data(md_data), .md_ack(md_ack),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ack(dbg_ack),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .stall(stall)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // Model state: who gets the next shared slot, how long each side has waited, and
   // the outputs expected after the coming edge.
   bit          m_next_dbg;
   int          m_md_wait, m_dbg_wait;
   bit          m_stall;
   bit          e_rf_we, e_md_ack, e_dbg_ack;
   logic [4:0]  e_rf_addr;
   logic [31:0] e_rf_data;
   int          md_ack_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int who; // 0 none, 1 wb, 2 md, 3 dbg
      bit md_ok, dbg_ok, starving;
      int nmd, ndbg;
      logic [4:0]  a;
      logic [31:0] d;
      if (reset) begin
         m_next_dbg = 0; m_md_wait = 0; m_dbg_wait = 0; m_stall = 0;
         e_rf_we = 0; e_md_ack = 0; e_dbg_ack = 0; e_rf_addr = '0; e_rf_data = '0;
         return;
      end
      md_ok  = md_req  && !e_md_ack;
      dbg_ok = dbg_req && !e_dbg_ack;
      who = 0;
      if (wb_we) who = 1;
      else if (md_ok && dbg_ok) who = m_next_dbg ? 3 : 2;
      else if (md_ok) who = 2;
      else if (dbg_ok) who = 3;
      a = (who == 1) ? wb_addr : (who == 2) ? md_addr : dbg_addr;
      d = (who == 1) ? wb_data : (who == 2) ? md_data : dbg_data;
      starving = (m_md_wait == LIMIT && who != 2) || (m_dbg_wait == LIMIT && who != 3);
      nmd  = (!md_req  || who == 2) ? 0 : ((m_md_wait  + 1 > LIMIT) ? LIMIT : m_md_wait  + 1);
      ndbg = (!dbg_req || who == 3) ? 0 : ((m_dbg_wait + 1 > LIMIT) ? LIMIT : m_dbg_wait + 1);
      if (!m_stall) m_stall = starving;
      else          m_stall = (nmd == LIMIT) || (ndbg == LIMIT);
      m_md_wait = nmd; m_dbg_wait = ndbg;
      e_md_ack  = (who == 2);
      e_dbg_ack = (who == 3);
      if (who == 2) m_next_dbg = 1;
      if (who == 3) m_next_dbg = 0;
      e_rf_we = (who != 0) && (a != 0);
      if (e_rf_we) begin e_rf_addr = a; e_rf_data = d; end
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
      if (md_ack) md_ack_cnt++;
      chk("rf_we",   32'(rf_we),   32'(e_rf_we));
      chk("rf_addr", 32'(rf_addr), 32'(e_rf_addr));
      chk("rf_data", rf_data,      e_rf_data);
      chk("md_ack",  32'(md_ack),  32'(e_md_ack));
      chk("dbg_ack", 32'(dbg_ack), 32'(e_dbg_ack));
      chk("stall",   32'(stall),   32'(m_stall));
   endtask

   // Requesters drop a held request once they see its ack.
   task automatic release_acked();
      if (md_req && e_md_ack)   md_req  = 0;
      if (dbg_req && e_dbg_ack) dbg_req = 0;
   endtask

   initial begin
      int cyc;
      reset = 1; wb_we = 0; wb_addr = 0; wb_data = 0;
      md_req = 0; md_addr = 0; md_data = 0; dbg_req = 0; dbg_addr = 0; dbg_data = 0;
      md_ack_cnt = 0;
      m_next_dbg = 0; m_md_wait = 0; m_dbg_wait = 0; m_stall = 0;
      e_rf_we = 0; e_md_ack = 0; e_dbg_ack = 0; e_rf_addr = '0; e_rf_data = '0;
      tick(); tick();
      chk("reset_rf_data", rf_data, 32'h0);
      reset = 0;

      // Writeback pass-through
      wb_we = 1; wb_addr = 5; wb_data = 32'h1234;
      tick();
      chk("wb_rf_addr", 32'(rf_addr), 32'd5);
      chk("wb_rf_data", rf_data, 32'h1234);
      wb_we = 0;
      tick();

      // Simultaneous md/dbg after reset: md first, then dbg
      reset = 1; tick(); reset = 0;
      md_req = 1; md_addr = 7; md_data = 32'hAAAA0001;
      dbg_req = 1; dbg_addr = 9; dbg_data = 32'hBBBB0002;
      tick();
      chk("rr_md_first", 32'(md_ack), 32'd1);
      release_acked();
      tick();
      chk("rr_dbg_second", 32'(dbg_ack), 32'd1);
      chk("rr_dbg_data", rf_data, 32'hBBBB0002);
      release_acked();
      tick();

      // Starvation under continuous writeback
      wb_we = 1; wb_addr = 3; wb_data = 32'h55;
      md_req = 1; md_addr = 12; md_data = 32'hC0DE;
      for (int i = 0; i < 7; i++) tick();
      chk("stall_not_yet", 32'(stall), 32'd0);
      tick();
      chk("stall_raised", 32'(stall), 32'd1);
      wb_we = 0;
      tick();
      chk("starved_md_ack", 32'(md_ack), 32'd1);
      chk("starved_md_data", rf_data, 32'hC0DE);
      chk("stall_dropped", 32'(stall), 32'd0);
      release_acked();
      tick();

      // Debug write to register 0 is acked but not written
      dbg_req = 1; dbg_addr = 0; dbg_data = 32'hFFFFFFFF;
      tick();
      chk("r0_dbg_ack", 32'(dbg_ack), 32'd1);
      chk("r0_no_we", 32'(rf_we), 32'd0);
      chk("r0_data_hold", rf_data, 32'hC0DE);
      release_acked();
      tick();

      // Grant lost to reset, then retried exactly once
      md_ack_cnt = 0;
      md_req = 1; md_addr = 4; md_data = 32'h0BAD;
      reset = 1;
      tick();
      chk("rst_md_ack", 32'(md_ack), 32'd0);
      chk("rst_rf_addr", 32'(rf_addr), 32'd0);
      reset = 0;
      tick();
      release_acked();
      for (int i = 0; i < 3; i++) tick();
      chk("retry_ack_count", 32'(md_ack_cnt), 32'd1);

      // Random traffic with varying writeback pressure
      for (cyc = 0; cyc < 1500; cyc++) begin
         int wb_pct;
         wb_pct = (cyc / 250) % 2 ? 92 : 35;
         release_acked();
         if (md_req && $urandom_range(0, 59) == 0) md_req = 0;
         if (dbg_req && $urandom_range(0, 59) == 0) dbg_req = 0;
         if (!md_req && $urandom_range(0, 2) == 0) begin
            md_req = 1;
            md_addr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            md_data = $urandom;
         end
         if (!dbg_req && $urandom_range(0, 3) == 0) begin
            dbg_req = 1;
            dbg_addr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            dbg_data = $urandom;
         end
         wb_we = ($urandom_range(0, 99) < wb_pct);
         wb_addr = 5'($urandom);
         wb_data = $urandom;
         reset = ($urandom_range(0, 299) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
